// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//
// Shared definitions for the parameterised register file:
//   - state_e      : controller states (SCRUB clears the array, RUN is normal
//                    operation)
//   - DEF_*        : default values for the register file parameters
//
// No ports; imported by param_regfile and regfile_scoreboard.
// ---------------------------------------------------------------------------
package regfile_pkg;

    // Default register width in bits.
    localparam int unsigned DEF_DATA_W   = 32;

    // Default index width; the array holds 2**DEF_ADDR_W registers.
    localparam int unsigned DEF_ADDR_W   = 5;

    // Default for the hardwired-zero register 0 behaviour.
    localparam bit          DEF_ZERO_REG = 1'b1;

    // Controller states. SCRUB walks every index writing zero and clearing
    // the pending bit; RUN is the normal read/write mode.
    typedef enum logic [0:0] {
        SCRUB = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Tracks which registers still await a write from an in-flight producer.
// One pending bit per register:
//   - set   when a producer is issued to that index (RUN only),
//   - clear when the index is written (RUN only),
//   - clear when the scrub walks over the index (SCRUB only).
// A set and a clear to the same index in the same cycle leave the bit set,
// since the newly issued producer is younger than the one completing.
//
// Ports
//   clock        in   rising-edge clock
//   scrub_i      in   controller is in SCRUB
//   scrub_idx_i  in   index being scrubbed this cycle
//   run_i        in   controller is in RUN
//   set_i        in   issue a producer (already qualified by RUN)
//   set_addr_i   in   destination index of the issued producer
//   clr_i        in   register write this cycle (already qualified by RUN)
//   clr_addr_i   in   index being written
//   raddr1_i     in   read index, port 1
//   raddr2_i     in   read index, port 2
//   pend1_o      out  raddr1_i still awaits a write
//   pend2_o      out  raddr2_i still awaits a write
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = DEF_ZERO_REG
) (
    input  logic              clock,
    input  logic              scrub_i,
    input  logic [ADDR_W-1:0] scrub_idx_i,
    input  logic              run_i,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic              pend1_o,
    output logic              pend2_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // Register 0 never becomes pending when it is hardwired to zero.
    logic set_ok;
    assign set_ok = set_i && !(ZERO_REG && (set_addr_i == '0));

    always_comb begin
        pending_d = pending_q;
        if (scrub_i) begin
            pending_d[scrub_idx_i] = 1'b0;
        end else begin
            // Clear first, then set, so a same-index set overrides the clear.
            if (clr_i) begin
                pending_d[clr_addr_i] = 1'b0;
            end
            if (set_ok) begin
                pending_d[set_addr_i] = 1'b1;
            end
        end
    end

    // The pending vector is brought to a known state by the scrub pass that
    // always follows reset, so the flops themselves carry no reset.
    always_ff @(posedge clock) begin
        pending_q <= pending_d;
    end

    // A write landing this cycle already satisfies the reader, so the bit is
    // masked for a matching read index (mirrors the data bypass).
    function automatic logic pend_view(input logic [ADDR_W-1:0] ra,
                                       input logic             run,
                                       input logic [DEPTH-1:0] pend_vec,
                                       input logic             wr,
                                       input logic [ADDR_W-1:0] wa);
        logic hit_zero;
        hit_zero  = ZERO_REG && (ra == '0);
        pend_view = run && pend_vec[ra] && !(wr && (wa == ra)) && !hit_zero;
    endfunction

    assign pend1_o = pend_view(raddr1_i, run_i, pending_q, clr_i, clr_addr_i);
    assign pend2_o = pend_view(raddr2_i, run_i, pending_q, clr_i, clr_addr_i);

endmodule : regfile_scoreboard

// File: rtl/param_regfile.sv
// ---------------------------------------------------------------------------
// param_regfile
//
// Parameterised register file with two combinational read ports, one write
// port with write-through bypass, an optional hardwired-zero register 0, and
// a pending-write scoreboard. After reset a scrub pass writes zero to every
// register (one per cycle) before the block becomes usable.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    index width; depth = 2**ADDR_W
//   ZERO_REG  1 = register 0 always reads 0 and ignores writes
//
// Ports
//   clock      in   sole clock, rising edge
//   reset      in   synchronous active-high reset
//   we         in   write enable
//   waddr      in   write index
//   wdata      in   write value
//   raddr1/2   in   read indices
//   rdata1/2   out  read values (combinational)
//   iss_valid  in   a new producer is in flight
//   iss_addr   in   destination index of that producer
//   pend1/2    out  read index is awaiting a pending write
//   busy       out  scrub in progress; block not usable
// ---------------------------------------------------------------------------
module param_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = DEF_ZERO_REG
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              pend1,
    output logic              pend2,
    output logic              busy
);

    localparam int unsigned     DEPTH    = 1 << ADDR_W;
    // The scrub index is one bit wider than an address so the terminal
    // count is compared before anything could wrap.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

    // -----------------------------------------------------------------------
    // Controller
    // -----------------------------------------------------------------------
    state_e          state_q;
    state_e          state_d;
    logic [ADDR_W:0] idx_q;
    logic [ADDR_W:0] idx_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SCRUB;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            SCRUB: begin
                idx_d = idx_q + IDX_ONE;
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = SCRUB;
                idx_d   = '0;
            end
        endcase
    end

    logic              scrub;
    logic              run;
    logic [ADDR_W-1:0] scrub_idx;

    assign scrub     = (state_q == SCRUB);
    assign run       = (state_q == RUN);
    assign scrub_idx = idx_q[ADDR_W-1:0];
    assign busy      = scrub;

    // Writes and issues only count in RUN; both are ignored while scrubbing.
    logic run_we;
    logic run_iss;
    logic wr_en;

    assign run_we  = run && we;
    assign run_iss = run && iss_valid;
    assign wr_en   = run_we && !(ZERO_REG && (waddr == '0));

    // -----------------------------------------------------------------------
    // Register array
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset branch; it is cleared by the scrub pass,
    // which keeps it mappable onto plain RAM/flops without a reset tree.
    always_ff @(posedge clock) begin
        if (scrub) begin
            mem_q[scrub_idx] <= '0;
        end else if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read priority: scrub blanking, hardwired zero, same-cycle write bypass,
    // then the stored value.
    function automatic logic [DATA_W-1:0] read_mux(
        input logic              is_run,
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              wr,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        if (!is_run) begin
            read_mux = '0;
        end else if (ZERO_REG && (ra == '0)) begin
            read_mux = '0;
        end else if (wr && (wa == ra)) begin
            read_mux = wd;
        end else begin
            read_mux = stored;
        end
    endfunction

    assign rdata1 = read_mux(run, raddr1, mem_q[raddr1], run_we, waddr, wdata);
    assign rdata2 = read_mux(run, raddr2, mem_q[raddr2], run_we, waddr, wdata);

    // -----------------------------------------------------------------------
    // Pending-write scoreboard
    // -----------------------------------------------------------------------
    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock       (clock),
        .scrub_i     (scrub),
        .scrub_idx_i (scrub_idx),
        .run_i       (run),
        .set_i       (run_iss),
        .set_addr_i  (iss_addr),
        .clr_i       (run_we),
        .clr_addr_i  (waddr),
        .raddr1_i    (raddr1),
        .raddr2_i    (raddr2),
        .pend1_o     (pend1),
        .pend2_o     (pend2)
    );

endmodule : param_regfile

// File: tb/tb_param_regfile.sv
// ---------------------------------------------------------------------------
// tb_param_regfile
//
// Directed bench for param_regfile at default parameters (32-bit, 32 regs,
// register 0 hardwired to zero). Inputs change 1 time unit after a rising
// edge; outputs are sampled 1 time unit after that, well before the next edge.
// ---------------------------------------------------------------------------
module tb_param_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic          iss_valid;
    logic [AW-1:0] iss_addr;
    logic          pend1;
    logic          pend2;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    param_regfile dut (
        .clock     (clock),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .pend1     (pend1),
        .pend2     (pend2),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns just after the edge so inputs can be driven.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        we        = 1'b0;
        iss_valid = 1'b0;
    endtask

    // Count cycles with busy high, bounded so a stuck scrub still terminates.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && (n < 200)) begin
            n++;
            step();
        end
    endtask

    int n_busy;

    initial begin
        reset     = 1'b1;
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        raddr1    = '0;
        raddr2    = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;

        // ---- reset and initial scrub, with writes/issues offered meanwhile
        step();
        step();
        reset     = 1'b0;
        we        = 1'b1;
        waddr     = 5'd4;
        wdata     = 32'd7;
        iss_valid = 1'b1;
        iss_addr  = 5'd5;
        raddr1    = 5'd4;
        raddr2    = 5'd5;
        settle();
        check("busy_after_reset", busy, 1);
        check("scrub_rdata1", rdata1, 0);
        check("scrub_pend2", pend2, 0);
        count_busy(n_busy);
        check("scrub_cycles", n_busy, 32);
        idle();
        settle();
        check("run_busy_low", busy, 0);
        check("scrub_write_ignored", rdata1, 0);
        check("scrub_issue_ignored", pend2, 0);

        // ---- every register reads zero and nothing is pending
        for (int i = 0; i < 32; i++) begin
            raddr1 = AW'(i);
            raddr2 = AW'(31 - i);
            settle();
            check("init_rdata1", rdata1, 0);
            check("init_rdata2", rdata2, 0);
            check("init_pend1", pend1, 0);
        end

        // ---- write-through bypass and stored value
        we     = 1'b1;
        waddr  = 5'd6;
        wdata  = 32'h38;
        raddr1 = 5'd6;
        raddr2 = 5'd7;
        settle();
        check("bypass_rdata1", rdata1, 32'h38);
        check("bypass_other_port", rdata2, 0);
        step();
        idle();
        settle();
        check("stored_rdata1", rdata1, 32'h38);

        // ---- register 0 hardwired to zero
        we     = 1'b1;
        waddr  = 5'd0;
        wdata  = 32'hFFFF_FFFF;
        raddr2 = 5'd0;
        settle();
        check("zero_bypass", rdata2, 0);
        step();
        idle();
        settle();
        check("zero_stored", rdata2, 0);

        // ---- pending scoreboard
        iss_valid = 1'b1;
        iss_addr  = 5'd9;
        raddr1    = 5'd9;
        settle();
        check("pend_not_yet", pend1, 0);
        step();
        idle();
        raddr2 = 5'd9;
        settle();
        check("pend1_set", pend1, 1);
        check("pend2_same_index", pend2, 1);
        we    = 1'b1;
        waddr = 5'd9;
        wdata = 32'h99;
        settle();
        check("pend_write_cycle", pend1, 0);
        check("pend_write_data", rdata1, 32'h99);
        step();
        idle();
        settle();
        check("pend_cleared", pend1, 0);
        check("rdata_reg9", rdata1, 32'h99);
        raddr1 = 5'd6;
        settle();
        check("two_port_p1", rdata1, 32'h38);
        check("two_port_p2", rdata2, 32'h99);

        // simultaneous issue and write to the same index: set wins
        raddr1    = 5'd9;
        iss_valid = 1'b1;
        iss_addr  = 5'd9;
        we        = 1'b1;
        waddr     = 5'd9;
        wdata     = 32'hAA;
        settle();
        check("pend_same_cycle_mask", pend1, 0);
        step();
        idle();
        settle();
        check("pend_set_wins", pend1, 1);
        check("rdata_reg9_aa", rdata1, 32'hAA);

        // a write elsewhere leaves index 9 pending; issue to 0 is ignored
        iss_valid = 1'b1;
        iss_addr  = 5'd12;
        step();
        idle();
        we    = 1'b1;
        waddr = 5'd12;
        wdata = 32'h12;
        iss_valid = 1'b1;
        iss_addr  = 5'd0;
        raddr2    = 5'd12;
        settle();
        check("pend_other_kept", pend1, 1);
        check("pend12_write_mask", pend2, 0);
        step();
        idle();
        raddr2 = 5'd0;
        settle();
        check("pend_zero_reg", pend2, 0);

        // ---- reset during scrub restarts it
        we     = 1'b1;
        waddr  = 5'd3;
        wdata  = 32'h55;
        step();
        idle();
        raddr1 = 5'd3;
        settle();
        check("reg3_written", rdata1, 32'h55);
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        check("busy_on_reset", busy, 1);
        for (int i = 0; i < 10; i++) step();
        settle();
        check("busy_mid_scrub", busy, 1);
        check("scrub_read_blank", rdata1, 0);
        reset = 1'b1;
        step();
        step();
        step();
        settle();
        check("busy_reset_held", busy, 1);
        reset = 1'b0;
        count_busy(n_busy);
        check("rescrub_cycles", n_busy, 32);
        raddr1 = 5'd3;
        raddr2 = 5'd9;
        settle();
        check("reg3_after_rescrub", rdata1, 0);
        check("reg9_after_rescrub", rdata2, 0);
        check("pend9_after_rescrub", pend2, 0);
        raddr1 = 5'd6;
        settle();
        check("reg6_after_rescrub", rdata1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_param_regfile
